// File: rtl/order_table_ctrl.sv
// Order-table manager: free-list slot allocation, ownership-checked FILL/DELETE/READ
// and fill accounting. Optional occupancy/high-water stats under ORDER_TABLE_STATS_EN.
module order_table_ctrl #(
    parameter int ORDER_TABLE_SIZE = 1024,
    parameter int MAX_CLIENTS      = 4,
    parameter int QTY_WIDTH        = 32,
    parameter int PRICE_WIDTH      = 64,
    localparam int IDX_W           = $clog2(ORDER_TABLE_SIZE),
    localparam int CLI_W           = $clog2(MAX_CLIENTS)
) (
    input  logic                   clk,
    input  logic                   areset,
    input  logic                   cmd_valid,
    output logic                   cmd_ready,
    input  logic [1:0]             cmd_op,
    input  logic [IDX_W-1:0]       cmd_index,
    input  logic [CLI_W-1:0]       cmd_client,
    input  logic [15:0]            cmd_instrument,
    input  logic                   cmd_buy,
    input  logic [QTY_WIDTH-1:0]   cmd_quantity,
    input  logic [PRICE_WIDTH-1:0] cmd_price,
    output logic                   rsp_valid,
    input  logic                   rsp_ready,
    output logic [1:0]             rsp_status,
    output logic [IDX_W-1:0]       rsp_index,
    output logic [QTY_WIDTH-1:0]   rsp_filled,
    output logic [QTY_WIDTH-1:0]   rsp_quantity,
    output logic                   rsp_removed,
    output logic [IDX_W:0]         occupancy,
    output logic [IDX_W:0]         high_water
);

    localparam logic [1:0] OP_INSERT = 2'd0;
    localparam logic [1:0] OP_FILL   = 2'd1;
    localparam logic [1:0] OP_DELETE = 2'd2;

    localparam logic [1:0] ST_OK         = 2'd0;
    localparam logic [1:0] ST_FULL       = 2'd1;
    localparam logic [1:0] ST_NOT_FOUND  = 2'd2;
    localparam logic [1:0] ST_BAD_CLIENT = 2'd3;

    localparam logic [IDX_W-1:0] IDX_ONE  = IDX_W'(1);
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(ORDER_TABLE_SIZE - 1);
    localparam logic [IDX_W:0]   CNT_ONE  = (IDX_W + 1)'(1);

    typedef enum logic [1:0] {
        S_INIT,
        S_IDLE,
        S_LOOKUP,
        S_RESPOND
    } state_t;

    typedef struct packed {
        logic [CLI_W-1:0]       client;
        logic [15:0]            instrument;
        logic                   buy;
        logic [QTY_WIDTH-1:0]   quantity;
        logic [QTY_WIDTH-1:0]   filled;
        logic [PRICE_WIDTH-1:0] price;
    } entry_t;

    state_t                  r_state;
    logic                    r_cmdReady;
    logic [IDX_W-1:0]        r_initCnt;
    logic [ORDER_TABLE_SIZE-1:0] r_valid;
    entry_t                  r_table [ORDER_TABLE_SIZE];
    logic [IDX_W-1:0]        r_freeMem [ORDER_TABLE_SIZE];
    logic [IDX_W-1:0]        r_freeHead;
    logic [IDX_W-1:0]        r_freeTail;
    logic [IDX_W:0]          r_freeCount;

    logic [1:0]              r_cmdOp;
    logic [IDX_W-1:0]        r_cmdIndex;
    logic [CLI_W-1:0]        r_cmdClient;
    logic [15:0]             r_cmdInstrument;
    logic                    r_cmdBuy;
    logic [QTY_WIDTH-1:0]    r_cmdQty;
    logic [PRICE_WIDTH-1:0]  r_cmdPrice;
    logic                    r_rdValid;
    entry_t                  r_rdEntry;

    logic                    r_rspValid;
    logic [1:0]              r_rspStatus;
    logic [IDX_W-1:0]        r_rspIndex;
    logic [QTY_WIDTH-1:0]    r_rspFilled;
    logic [QTY_WIDTH-1:0]    r_rspQty;
    logic                    r_rspRemoved;

    logic                    w_accept;
    logic [IDX_W-1:0]        w_popIdx;
    logic [QTY_WIDTH:0]      w_fillSum;
    logic                    w_fillDone;
    logic [QTY_WIDTH-1:0]    w_filledNew;
    logic                    w_insert;
    logic                    w_fillWr;
    logic                    w_clrValid;
    logic [1:0]              w_status;
    logic [IDX_W-1:0]        w_rspIdx;
    logic [QTY_WIDTH-1:0]    w_rspFilled;
    logic [QTY_WIDTH-1:0]    w_rspQty;
    logic                    w_pushFree;
    logic [IDX_W-1:0]        w_pushIdx;
    logic                    w_wrEn;
    logic [IDX_W-1:0]        w_wrIdx;
    entry_t                  w_newEntry;
    entry_t                  w_fillEntry;
    entry_t                  w_wrData;

    assign w_accept    = cmd_valid && r_cmdReady;
    assign w_popIdx    = r_freeMem[r_freeHead];
    // One spare bit on the sum so an oversized fill saturates instead of wrapping.
    assign w_fillSum   = {1'b0, r_rdEntry.filled} + {1'b0, r_cmdQty};
    assign w_fillDone  = (w_fillSum >= {1'b0, r_rdEntry.quantity});
    assign w_filledNew = w_fillDone ? r_rdEntry.quantity : w_fillSum[QTY_WIDTH-1:0];

    always_comb begin
        w_status    = ST_OK;
        w_rspIdx    = r_cmdIndex;
        w_rspFilled = '0;
        w_rspQty    = '0;
        w_insert    = 1'b0;
        w_fillWr    = 1'b0;
        w_clrValid  = 1'b0;
        if (r_state == S_LOOKUP) begin
            if (r_cmdOp == OP_INSERT) begin
                if (r_freeCount == '0) begin
                    w_status = ST_FULL;
                end else begin
                    w_insert = 1'b1;
                    w_rspIdx = w_popIdx;
                    w_rspQty = r_cmdQty;
                end
            end else if (!r_rdValid) begin
                w_status = ST_NOT_FOUND;
            end else if (r_rdEntry.client != r_cmdClient) begin
                w_status = ST_BAD_CLIENT;
            end else begin
                w_rspQty    = r_rdEntry.quantity;
                w_rspFilled = r_rdEntry.filled;
                if (r_cmdOp == OP_FILL) begin
                    w_rspFilled = w_filledNew;
                    if (w_fillDone) begin
                        w_clrValid = 1'b1;
                    end else begin
                        w_fillWr = 1'b1;
                    end
                end else if (r_cmdOp == OP_DELETE) begin
                    w_clrValid = 1'b1;
                end
            end
        end
    end

    always_comb begin
        w_newEntry            = '0;
        w_newEntry.client     = r_cmdClient;
        w_newEntry.instrument = r_cmdInstrument;
        w_newEntry.buy        = r_cmdBuy;
        w_newEntry.quantity   = r_cmdQty;
        w_newEntry.price      = r_cmdPrice;
        w_fillEntry           = r_rdEntry;
        w_fillEntry.filled    = w_filledNew;
    end

    assign w_wrEn     = w_insert || w_fillWr;
    assign w_wrIdx    = w_insert ? w_popIdx : r_cmdIndex;
    assign w_wrData   = w_insert ? w_newEntry : w_fillEntry;
    assign w_pushFree = (r_state == S_INIT) || w_clrValid;
    assign w_pushIdx  = (r_state == S_INIT) ? r_initCnt : r_cmdIndex;

    // Entry payload and free-list storage carry no reset; validity lives in r_valid.
    always_ff @(posedge clk) begin
        if (w_accept) begin
            r_rdEntry <= r_table[cmd_index];
        end
        if (w_wrEn) begin
            r_table[w_wrIdx] <= w_wrData;
        end
        if (w_pushFree) begin
            r_freeMem[r_freeTail] <= w_pushIdx;
        end
    end

    always_ff @(posedge clk or posedge areset) begin
        if (areset) begin
            r_state         <= S_INIT;
            r_cmdReady      <= 1'b0;
            r_initCnt       <= '0;
            r_valid         <= '0;
            r_freeHead      <= '0;
            r_freeTail      <= '0;
            r_freeCount     <= '0;
            r_cmdOp         <= '0;
            r_cmdIndex      <= '0;
            r_cmdClient     <= '0;
            r_cmdInstrument <= '0;
            r_cmdBuy        <= 1'b0;
            r_cmdQty        <= '0;
            r_cmdPrice      <= '0;
            r_rdValid       <= 1'b0;
            r_rspValid      <= 1'b0;
            r_rspStatus     <= '0;
            r_rspIndex      <= '0;
            r_rspFilled     <= '0;
            r_rspQty        <= '0;
            r_rspRemoved    <= 1'b0;
        end else begin
            if (w_pushFree) begin
                r_freeTail  <= r_freeTail + IDX_ONE;
                r_freeCount <= r_freeCount + CNT_ONE;
            end else if (w_insert) begin
                r_freeHead  <= r_freeHead + IDX_ONE;
                r_freeCount <= r_freeCount - CNT_ONE;
            end
            case (r_state)
                S_INIT: begin
                    r_initCnt <= r_initCnt + IDX_ONE;
                    if (r_initCnt == IDX_LAST) begin
                        r_state    <= S_IDLE;
                        r_cmdReady <= 1'b1;
                    end
                end
                S_IDLE: begin
                    if (w_accept) begin
                        r_cmdOp         <= cmd_op;
                        r_cmdIndex      <= cmd_index;
                        r_cmdClient     <= cmd_client;
                        r_cmdInstrument <= cmd_instrument;
                        r_cmdBuy        <= cmd_buy;
                        r_cmdQty        <= cmd_quantity;
                        r_cmdPrice      <= cmd_price;
                        r_rdValid       <= r_valid[cmd_index];
                        r_cmdReady      <= 1'b0;
                        r_state         <= S_LOOKUP;
                    end
                end
                S_LOOKUP: begin
                    if (w_insert) begin
                        r_valid[w_popIdx] <= 1'b1;
                    end
                    if (w_clrValid) begin
                        r_valid[r_cmdIndex] <= 1'b0;
                    end
                    r_rspStatus  <= w_status;
                    r_rspIndex   <= w_rspIdx;
                    r_rspFilled  <= w_rspFilled;
                    r_rspQty     <= w_rspQty;
                    r_rspRemoved <= w_clrValid;
                    r_state      <= S_RESPOND;
                end
                S_RESPOND: begin
                    // Fields settle one cycle before rsp_valid rises, giving the fixed two-cycle latency.
                    if (!r_rspValid) begin
                        r_rspValid <= 1'b1;
                    end else if (rsp_ready) begin
                        r_rspValid <= 1'b0;
                        r_cmdReady <= 1'b1;
                        r_state    <= S_IDLE;
                    end
                end
                default: r_state <= S_INIT;
            endcase
        end
    end

`ifdef ORDER_TABLE_STATS_EN
    logic [IDX_W:0] r_occupancy;
    logic [IDX_W:0] r_highWater;
    logic [IDX_W:0] w_occUp;

    assign w_occUp = r_occupancy + CNT_ONE;

    always_ff @(posedge clk or posedge areset) begin
        if (areset) begin
            r_occupancy <= '0;
            r_highWater <= '0;
        end else if (w_insert) begin
            r_occupancy <= w_occUp;
            if (w_occUp > r_highWater) begin
                r_highWater <= w_occUp;
            end
        end else if (w_clrValid) begin
            r_occupancy <= r_occupancy - CNT_ONE;
        end
    end

    assign occupancy  = r_occupancy;
    assign high_water = r_highWater;
`else
    assign occupancy  = '0;
    assign high_water = '0;
`endif

    assign cmd_ready    = r_cmdReady;
    assign rsp_valid    = r_rspValid;
    assign rsp_status   = r_rspStatus;
    assign rsp_index    = r_rspIndex;
    assign rsp_filled   = r_rspFilled;
    assign rsp_quantity = r_rspQty;
    assign rsp_removed  = r_rspRemoved;

endmodule

// File: tb/tb_order_table_ctrl.sv
// Directed bench for order_table_ctrl on a 4-slot table: init timing, insert/fill/delete/read,
// ownership checks, table-full recycling, response back-pressure and reset mid-command.
module tb_order_table_ctrl;

   localparam int SIZE = 4;
   localparam logic [1:0] OP_INSERT = 2'd0;
   localparam logic [1:0] OP_FILL   = 2'd1;
   localparam logic [1:0] OP_DELETE = 2'd2;
   localparam logic [1:0] OP_READ   = 2'd3;
   localparam logic [1:0] ST_OK         = 2'd0;
   localparam logic [1:0] ST_FULL       = 2'd1;
   localparam logic [1:0] ST_NOT_FOUND  = 2'd2;
   localparam logic [1:0] ST_BAD_CLIENT = 2'd3;
`ifdef ORDER_TABLE_STATS_EN
   localparam bit STATS = 1'b1;
`else
   localparam bit STATS = 1'b0;
`endif

   logic        clk = 1'b0;
   logic        areset = 1'b1;
   logic        cmd_valid = 1'b0;
   logic        cmd_ready;
   logic [1:0]  cmd_op = '0;
   logic [1:0]  cmd_index = '0;
   logic [1:0]  cmd_client = '0;
   logic [15:0] cmd_instrument = '0;
   logic        cmd_buy = 1'b0;
   logic [31:0] cmd_quantity = '0;
   logic [63:0] cmd_price = '0;
   logic        rsp_valid;
   logic        rsp_ready = 1'b0;
   logic [1:0]  rsp_status;
   logic [1:0]  rsp_index;
   logic [31:0] rsp_filled;
   logic [31:0] rsp_quantity;
   logic        rsp_removed;
   logic [2:0]  occupancy;
   logic [2:0]  high_water;

   int checks = 0;
   int errors = 0;
   int latency;
   int readyCycles;
   bit acceptSeen;

   order_table_ctrl #(
      .ORDER_TABLE_SIZE(SIZE),
      .MAX_CLIENTS(4),
      .QTY_WIDTH(32),
      .PRICE_WIDTH(64)
   ) dut (
      .clk(clk),
      .areset(areset),
      .cmd_valid(cmd_valid),
      .cmd_ready(cmd_ready),
      .cmd_op(cmd_op),
      .cmd_index(cmd_index),
      .cmd_client(cmd_client),
      .cmd_instrument(cmd_instrument),
      .cmd_buy(cmd_buy),
      .cmd_quantity(cmd_quantity),
      .cmd_price(cmd_price),
      .rsp_valid(rsp_valid),
      .rsp_ready(rsp_ready),
      .rsp_status(rsp_status),
      .rsp_index(rsp_index),
      .rsp_filled(rsp_filled),
      .rsp_quantity(rsp_quantity),
      .rsp_removed(rsp_removed),
      .occupancy(occupancy),
      .high_water(high_water)
   );

   always #5 clk = ~clk;

   // One immediate assertion per comparison; the failure counter feeds the summary line.
   task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
      checks++;
      assert (observed === expected)
      else begin
         errors++;
         $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
      end
   endtask

   // Drives one command and returns right after the accepting edge (bounded wait).
   task automatic issueCmd(input logic [1:0] op, input logic [1:0] idx, input logic [1:0] cli,
                           input logic [31:0] qty, input logic [63:0] price);
      int n;
      @(negedge clk);
      cmd_op = op;
      cmd_index = idx;
      cmd_client = cli;
      cmd_instrument = 16'h00A5;
      cmd_buy = 1'b1;
      cmd_quantity = qty;
      cmd_price = price;
      cmd_valid = 1'b1;
      n = 0;
      while (!cmd_ready && n < 40) begin
         @(negedge clk);
         n++;
      end
      acceptSeen = cmd_ready;
      @(posedge clk);
      #1;
      cmd_valid = 1'b0;
   endtask

   // Issues a command and counts cycles from the accepting edge until rsp_valid.
   task automatic applyStimulus(input logic [1:0] op, input logic [1:0] idx, input logic [1:0] cli,
                                input logic [31:0] qty, input logic [63:0] price);
      issueCmd(op, idx, cli, qty, price);
      latency = 0;
      while (latency < 20) begin
         @(posedge clk);
         #1;
         latency++;
         if (rsp_valid) break;
      end
   endtask

   task automatic releaseRsp();
      @(negedge clk);
      rsp_ready = 1'b1;
      @(posedge clk);
      #1;
      rsp_ready = 1'b0;
   endtask

   task automatic waitReady();
      readyCycles = 0;
      while (readyCycles < 50) begin
         @(posedge clk);
         #1;
         readyCycles++;
         if (cmd_ready) break;
      end
   endtask

   task automatic expectRsp(input string tag, input logic [1:0] status, input logic [1:0] idx,
                            input logic [31:0] filled, input logic [31:0] qty, input logic removed);
      checkOutput({tag, "_accept"}, 64'(acceptSeen), 64'd1);
      checkOutput({tag, "_latency"}, 64'(latency), 64'd2);
      checkOutput({tag, "_status"}, 64'(rsp_status), 64'(status));
      checkOutput({tag, "_index"}, 64'(rsp_index), 64'(idx));
      checkOutput({tag, "_filled"}, 64'(rsp_filled), 64'(filled));
      checkOutput({tag, "_qty"}, 64'(rsp_quantity), 64'(qty));
      checkOutput({tag, "_removed"}, 64'(rsp_removed), 64'(removed));
      releaseRsp();
   endtask

   initial begin
      logic [1:0]  holdStatus;
      logic [31:0] holdFilled;
      logic [31:0] holdQty;
      bit          holdStable;
      bit          readySeen;

      // Reset state and INIT duration
      repeat (3) @(posedge clk);
      #1;
      checkOutput("reset_cmd_ready", 64'(cmd_ready), 64'd0);
      checkOutput("reset_rsp_valid", 64'(rsp_valid), 64'd0);
      checkOutput("reset_occupancy", 64'(occupancy), 64'd0);
      @(negedge clk);
      areset = 1'b0;
      waitReady();
      checkOutput("init_cycles", 64'(readyCycles), 64'(SIZE));
      checkOutput("init_occupancy", 64'(occupancy), 64'd0);

      // Allocation in free-list order
      applyStimulus(OP_INSERT, 2'd3, 2'd1, 32'd100, 64'd5);
      expectRsp("ins0", ST_OK, 2'd0, 32'd0, 32'd100, 1'b0);
      applyStimulus(OP_INSERT, 2'd0, 2'd1, 32'd50, 64'd7);
      expectRsp("ins1", ST_OK, 2'd1, 32'd0, 32'd50, 1'b0);

      // Partial fill, completing fill with auto-removal, then lookup of the freed slot
      applyStimulus(OP_FILL, 2'd0, 2'd1, 32'd60, 64'd0);
      expectRsp("fill60", ST_OK, 2'd0, 32'd60, 32'd100, 1'b0);
      applyStimulus(OP_FILL, 2'd0, 2'd1, 32'd60, 64'd0);
      expectRsp("fill_done", ST_OK, 2'd0, 32'd100, 32'd100, 1'b1);
      applyStimulus(OP_READ, 2'd0, 2'd1, 32'd0, 64'd0);
      expectRsp("read_freed", ST_NOT_FOUND, 2'd0, 32'd0, 32'd0, 1'b0);

      // Foreign client is rejected and leaves the entry untouched
      applyStimulus(OP_FILL, 2'd1, 2'd2, 32'd10, 64'd0);
      expectRsp("fill_bad", ST_BAD_CLIENT, 2'd1, 32'd0, 32'd0, 1'b0);
      applyStimulus(OP_DELETE, 2'd1, 2'd2, 32'd0, 64'd0);
      expectRsp("del_bad", ST_BAD_CLIENT, 2'd1, 32'd0, 32'd0, 1'b0);
      applyStimulus(OP_READ, 2'd1, 2'd1, 32'd0, 64'd0);
      expectRsp("read_intact", ST_OK, 2'd1, 32'd0, 32'd50, 1'b0);
      applyStimulus(OP_FILL, 2'd1, 2'd1, 32'd0, 64'd0);
      expectRsp("fill_zero", ST_OK, 2'd1, 32'd0, 32'd50, 1'b0);

      // Free list now holds 2,3,0: fill the table, overflow, recycle slot 2
      applyStimulus(OP_INSERT, 2'd0, 2'd1, 32'd30, 64'd9);
      expectRsp("ins2", ST_OK, 2'd2, 32'd0, 32'd30, 1'b0);
      applyStimulus(OP_INSERT, 2'd0, 2'd1, 32'd40, 64'd9);
      expectRsp("ins3", ST_OK, 2'd3, 32'd0, 32'd40, 1'b0);
      applyStimulus(OP_INSERT, 2'd0, 2'd1, 32'd70, 64'd9);
      expectRsp("ins4", ST_OK, 2'd0, 32'd0, 32'd70, 1'b0);
      applyStimulus(OP_INSERT, 2'd0, 2'd1, 32'd11, 64'd9);
      checkOutput("full_status", 64'(rsp_status), 64'(ST_FULL));
      checkOutput("full_removed", 64'(rsp_removed), 64'd0);
      releaseRsp();
      checkOutput("full_occupancy", 64'(occupancy), STATS ? 64'd4 : 64'd0);
      applyStimulus(OP_DELETE, 2'd2, 2'd1, 32'd0, 64'd0);
      expectRsp("del2", ST_OK, 2'd2, 32'd0, 32'd30, 1'b1);
      applyStimulus(OP_INSERT, 2'd0, 2'd1, 32'd25, 64'd9);
      expectRsp("ins_recycle", ST_OK, 2'd2, 32'd0, 32'd25, 1'b0);
      checkOutput("high_water", 64'(high_water), STATS ? 64'd4 : 64'd0);

      // Back-pressure: response fields frozen and no new command accepted
      applyStimulus(OP_READ, 2'd3, 2'd1, 32'd0, 64'd0);
      holdStatus = rsp_status;
      holdFilled = rsp_filled;
      holdQty = rsp_quantity;
      holdStable = 1'b1;
      readySeen = 1'b0;
      repeat (10) begin
         @(posedge clk);
         #1;
         if (!rsp_valid || rsp_status !== holdStatus || rsp_filled !== holdFilled || rsp_quantity !== holdQty)
            holdStable = 1'b0;
         if (cmd_ready) readySeen = 1'b1;
      end
      checkOutput("hold_stable", 64'(holdStable), 64'd1);
      checkOutput("hold_cmd_ready", 64'(readySeen), 64'd0);
      expectRsp("hold_read", ST_OK, 2'd3, 32'd0, 32'd40, 1'b0);

      // Oversized fill saturates at quantity rather than wrapping
      applyStimulus(OP_FILL, 2'd3, 2'd1, 32'd10, 64'd0);
      expectRsp("fill10", ST_OK, 2'd3, 32'd10, 32'd40, 1'b0);
      applyStimulus(OP_FILL, 2'd3, 2'd1, 32'hFFFF_FFFF, 64'd0);
      expectRsp("fill_sat", ST_OK, 2'd3, 32'd40, 32'd40, 1'b1);
      checkOutput("occ_after_sat", 64'(occupancy), STATS ? 64'd3 : 64'd0);

      // Reset during LOOKUP: command dropped, table wiped, INIT reruns
      issueCmd(OP_INSERT, 2'd0, 2'd1, 32'd77, 64'd1);
      areset = 1'b1;
      repeat (2) @(posedge clk);
      #1;
      checkOutput("abort_rsp_valid", 64'(rsp_valid), 64'd0);
      checkOutput("abort_cmd_ready", 64'(cmd_ready), 64'd0);
      checkOutput("abort_rsp_qty", 64'(rsp_quantity), 64'd0);
      checkOutput("abort_high_water", 64'(high_water), 64'd0);
      @(negedge clk);
      areset = 1'b0;
      waitReady();
      checkOutput("reinit_cycles", 64'(readyCycles), 64'(SIZE));
      checkOutput("reinit_rsp_valid", 64'(rsp_valid), 64'd0);
      applyStimulus(OP_READ, 2'd1, 2'd1, 32'd0, 64'd0);
      expectRsp("read_wiped", ST_NOT_FOUND, 2'd1, 32'd0, 32'd0, 1'b0);
      applyStimulus(OP_INSERT, 2'd2, 2'd2, 32'd8, 64'd3);
      expectRsp("ins_after_reset", ST_OK, 2'd0, 32'd0, 32'd8, 1'b0);
      checkOutput("occ_after_reset", 64'(occupancy), STATS ? 64'd1 : 64'd0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/order_table_ctrl.md
Name: order_table_ctrl

Overview:
Parametrised order-table manager: owns an internal table of ORDER_TABLE_SIZE order entries plus a free-list of slot indices, and serves INSERT / FILL / DELETE / READ commands over a valid/ready command channel with a valid/ready response channel. Successor to the single-client, insert-only table writer. Adds multi-client ownership checks, slot allocation and recycling, fill accounting with auto-removal, and table-full handling. Sits between the client/exchange message decoders and the positions logic.

Parameters:
ORDER_TABLE_SIZE, 1024, number of table slots (power of two, >=4); IDX_W = $clog2(ORDER_TABLE_SIZE)
MAX_CLIENTS, 4, number of clients (>=2); CLI_W = $clog2(MAX_CLIENTS)
QTY_WIDTH, 32, width of quantity and filled fields
PRICE_WIDTH, 64, width of price field

Ports:
clk  in  1  clock
areset  in  1  asynchronous reset, active-high
cmd_valid  in  1  command present
cmd_ready  out  1  command accepted when valid&&ready
cmd_op  in  2  0=INSERT 1=FILL 2=DELETE 3=READ
cmd_index  in  IDX_W  target slot (FILL/DELETE/READ)
cmd_client  in  CLI_W  issuing client
cmd_instrument  in  16  instrument (INSERT)
cmd_buy  in  1  side (INSERT)
cmd_quantity  in  QTY_WIDTH  order qty (INSERT) / fill qty (FILL)
cmd_price  in  PRICE_WIDTH  price (INSERT)
rsp_valid  out  1  response present
rsp_ready  in  1  response consumed when valid&&ready
rsp_status  out  2  0=OK 1=FULL 2=NOT_FOUND 3=BAD_CLIENT
rsp_index  out  IDX_W  allocated/target slot
rsp_filled  out  QTY_WIDTH  filled after operation
rsp_quantity  out  QTY_WIDTH  entry quantity
rsp_removed  out  1  entry freed by this command
occupancy  out  IDX_W+1  slots in use (see Optional Feature)
high_water  out  IDX_W+1  peak occupancy since reset (see Optional Feature)

Behaviour:
- Reset: all rsp_* outputs 0, cmd_ready 0, occupancy/high_water 0, all valid bits cleared; FSM -> INIT. Reset at any point aborts the in-flight command; no response is issued for it.
- Each entry stores valid, client, instrument, buy, quantity, filled, price. Table reads are synchronous (1-cycle latency).
- FSM states: INIT, IDLE, LOOKUP, RESPOND.
- INIT: push indices 0..ORDER_TABLE_SIZE-1 into the free-list FIFO, one per cycle, in order. This takes ORDER_TABLE_SIZE cycles, then the FSM enters IDLE. cmd_ready is 0 throughout INIT.
- IDLE: cmd_ready=1. On accept, latch the command, issue the table read at cmd_index, and go to LOOKUP.
- LOOKUP (one cycle):
  - INSERT: if the free list is empty, status FULL and no write. Otherwise pop the head index, write the entry (valid=1, filled=0), status OK, rsp_index=popped.
  - FILL/DELETE/READ: if the entry is invalid, status NOT_FOUND. If entry client != cmd_client, status BAD_CLIENT. Either failure writes nothing.
  - FILL: filled_new = min(filled + cmd_quantity, quantity). Compute at QTY_WIDTH+1 bits, so no wrap. If filled_new == quantity, clear valid, push the index to the free list, rsp_removed=1. Otherwise write filled_new.
  - DELETE: clear valid, push the index, rsp_removed=1.
  - READ: no write.
  - Go to RESPOND.
- Response latency: rsp_valid rises exactly 2 cycles after the accepting edge.
- RESPOND: rsp_valid=1, all rsp_* fields held stable until rsp_ready. Return to IDLE on the cycle valid&&ready is seen. One command outstanding at most; cmd_ready=0 outside IDLE.
- FILL with cmd_quantity=0: OK, no change, rsp_removed=0 (unless quantity==0 and filled==0, which removes the entry).
- Free list never overflows: each index is held in exactly one place, either the FIFO or a valid entry.
- Failed commands change no state.

Optional Feature:
ORDER_TABLE_STATS_EN
- Defined: occupancy +1 on successful INSERT, -1 on any removal. high_water tracks the maximum occupancy value. Both reset to 0.
- Undefined: occupancy and high_water are tied to 0, and no counter logic is built.

Test Plan:
- Reset, count cycles until cmd_ready=1 -> exactly ORDER_TABLE_SIZE cycles after reset deasserts. Occupancy 0.
- INSERT client 1, qty 100, price 5 -> rsp OK, index 0, filled 0, 2 cycles after accept. Second INSERT -> index 1.
- FILL idx 0 client 1 qty 60 -> OK filled 60 removed 0. FILL qty 60 -> OK filled 100 removed 1. Next READ idx 0 -> NOT_FOUND.
- FILL/DELETE idx 1 with client 2 -> BAD_CLIENT. READ idx 1 afterwards shows the entry unchanged.
- SIZE=4: 4 INSERTs OK, 5th -> FULL. DELETE idx 2, then INSERT -> OK index 2. high_water=4 with STATS_EN.
- Hold rsp_ready=0 for 10 cycles -> rsp fields stable, cmd_ready 0. Assert areset mid-LOOKUP -> no response, INIT restarts, prior entries gone.
